stopwatch_run_control: RTL and testbench
========================================

Name: stopwatch_run_control

Overview:
- Upstream control stage for the two-digit 0–59 seconds counter and display path.
- Debounces the Load and Start push-buttons and captures a validated stop target from the slide switches.
- Runs a run/pause/done state machine that drives the counter enable and counter clear.
- Compares the live binary count against the captured target, replacing the free-running stop comparison.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable Clk cycles needed to accept a button level change (10 ms at 100 MHz).
- MAX_COUNT, 59, highest legal target value; also the counter's wrap value.
- CNT_W, 6, width of target, switch and count buses.

Ports:
- Clk  input  1  system clock, 100 MHz.
- Reset  input  1  synchronous, active-low reset; sampled on rising Clk.
- Load_Btn  input  1  raw, asynchronous push-button; requests target capture.
- Start_Btn  input  1  raw, asynchronous push-button; start/pause toggle.
- Stop  input  CNT_W  slide-switch target value, asynchronous.
- Count  input  CNT_W  current binary seconds value (tens*10 + ones) from the counter path.
- Target  output  CNT_W  captured stop target.
- Count_En  output  1  counter enable; high only in RUNNING.
- Counter_Clr  output  1  one-cycle pulse that clears the seconds counter.
- Done  output  1  high while in DONE.
- Load_Err  output  1  sticky flag: the last load attempt was out of range.

Behaviour:
- Reset is synchronous and active-low: on any rising Clk with Reset=0, all state returns to reset values. This applies mid-operation too.
- Reset values:
  - state = IDLE, Target = 0.
  - Count_En = 0, Counter_Clr = 0, Done = 0, Load_Err = 0.
  - Synchronizers, debounced levels and debounce counters = 0.
- Input sync: each button passes through 2 flip-flops. Stop is sampled only on an accepted load, and Stop is treated as quasi-static.
- Debounce (per button, independent):
  - The counter clears whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A 0→1 transition of the debounced level produces a one-cycle pulse (ld_p / st_p).
  - Latency from a clean raw edge to the pulse is 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- Load (ld_p), accepted in IDLE, ARMED, PAUSED and DONE:
  - If Stop <= MAX_COUNT: Target <= Stop, Load_Err <= 0, Counter_Clr pulses for 1 cycle, next state = ARMED.
  - If Stop > MAX_COUNT: Load_Err <= 1; Target and state are unchanged; no clear.
  - In RUNNING, ld_p is ignored; no flag change.
- Start (st_p) transitions:
  - ARMED→RUNNING.
  - RUNNING→PAUSED.
  - PAUSED→RUNNING.
  - Ignored in IDLE and DONE.
- Simultaneous ld_p and st_p in the same cycle: load is processed and st_p is discarded.
- Terminal compare, evaluated every cycle in RUNNING: if Count == Target, next state = DONE. This takes priority over st_p in the same cycle.
- Outputs are registered Moore decodes of the next state:
  - Count_En = 1 only in RUNNING.
  - Done = 1 only in DONE.
  - Count_En therefore falls on the same edge DONE is entered.
- Target = 0 case: entering RUNNING with Count = 0 reaches DONE one cycle later. No count increment occurs, since the counter ticks at 1 Hz.
- PAUSED holds Count_En = 0; Target and Count are retained.
- DONE holds until a valid load (→ARMED with clear) or reset. The counter never wraps past Target while enabled.

Test Plan:
- Reset=0 for 3 cycles mid-RUNNING with Target=20 → next cycle: state IDLE, Target=0, Count_En=0, Done=0, Load_Err=0.
- DEBOUNCE_CYCLES=4; Load_Btn high for 3 cycles then low → no Counter_Clr, Target unchanged. Then high for 10 cycles with Stop=25 → exactly one Counter_Clr pulse 6 cycles after the edge; Target=25; state ARMED.
- Stop=60, press Load → Load_Err=1, Target keeps 25, no clear. Then Stop=59, press Load → Load_Err=0, Target=59.
- Target=5, press Start → Count_En=1. Drive Count 0..5 → Count_En=0 and Done=1 on the edge after Count==5; later Start presses leave Done=1.
- In RUNNING, press Start → Count_En=0 (PAUSED), Target held. Press Start again → Count_En=1. Press Load while RUNNING with Stop=10 → ignored, Target unchanged.
- Load and Start debounced pulses coincide in ARMED with Stop=7 → Target=7, Counter_Clr pulse, state stays ARMED, Count_En=0. Target=0 with Count=0, press Start → Done=1 one cycle after RUNNING.

Source files
------------

// File: rtl/stopwatch_run_control.sv
// Run/pause/done control for the 0-59 s stopwatch: debounces Load/Start,
// captures a validated stop target and stops the counter when it is reached.
module stopwatch_run_control #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_COUNT       = 59,
  parameter int CNT_W           = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load_Btn,
  input  logic             Start_Btn,
  input  logic [CNT_W-1:0] Stop,
  input  logic [CNT_W-1:0] Count,
  output logic [CNT_W-1:0] Target,
  output logic             Count_En,
  output logic             Counter_Clr,
  output logic             Done,
  output logic             Load_Err
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_VALUE = CNT_W'(MAX_COUNT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RUNNING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Bit 0 is Load, bit 1 is Start.
  logic [1:0] btn_raw;
  logic [1:0] rise_pulse;
  logic       ld_p;
  logic       st_p;

  assign btn_raw = {Start_Btn, Load_Btn};
  assign ld_p    = rise_pulse[0];
  assign st_p    = rise_pulse[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            deb_reg;
      logic [DB_W-1:0] db_cnt_reg;

      always_ff @(posedge Clk) begin
        if (!Reset) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          deb_reg    <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == deb_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            deb_reg    <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
      end

      // Pulse is the cycle in which the debounced level is about to rise.
      assign rise_pulse[gi] = sync2_reg & ~deb_reg & (db_cnt_reg == DB_LAST);
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] target_reg, target_next;
  logic             load_err_reg, load_err_next;
  logic             clr_reg, clr_next;
  logic             count_en_reg;
  logic             done_reg;

  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    load_err_next = load_err_reg;
    clr_next      = 1'b0;
    if (state_reg == RUNNING) begin
      // Reaching the target wins over a pause request; loads are ignored here.
      if (Count == target_reg) begin
        state_next = DONE;
      end else if (st_p) begin
        state_next = PAUSED;
      end
    end else if (ld_p) begin
      if (Stop <= MAX_VALUE) begin
        target_next   = Stop;
        load_err_next = 1'b0;
        clr_next      = 1'b1;
        state_next    = ARMED;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (st_p && (state_reg == ARMED || state_reg == PAUSED)) begin
      state_next = RUNNING;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg    <= IDLE;
      target_reg   <= '0;
      load_err_reg <= 1'b0;
      clr_reg      <= 1'b0;
      count_en_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      target_reg   <= target_next;
      load_err_reg <= load_err_next;
      clr_reg      <= clr_next;
      count_en_reg <= (state_next == RUNNING);
      done_reg     <= (state_next == DONE);
    end
  end

  assign Target      = target_reg;
  assign Count_En    = count_en_reg;
  assign Counter_Clr = clr_reg;
  assign Done        = done_reg;
  assign Load_Err    = load_err_reg;

endmodule

// File: tb/tb_stopwatch_run_control.sv
// Directed bench for stopwatch_run_control with a short debounce window.
module tb_stopwatch_run_control;

  localparam int DB = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Load_Btn;
  logic       Start_Btn;
  logic [5:0] Stop;
  logic [5:0] Count;
  logic [5:0] Target;
  logic       Count_En;
  logic       Counter_Clr;
  logic       Done;
  logic       Load_Err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int clr_cnt = 0;
  int clr_base;

  stopwatch_run_control #(
    .DEBOUNCE_CYCLES(DB),
    .MAX_COUNT(59),
    .CNT_W(6)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Load_Btn(Load_Btn),
    .Start_Btn(Start_Btn),
    .Stop(Stop),
    .Count(Count),
    .Target(Target),
    .Count_En(Count_En),
    .Counter_Clr(Counter_Clr),
    .Done(Done),
    .Load_Err(Load_Err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Reset && Counter_Clr) clr_cnt++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Hold the buttons long enough to debounce, then release and let it settle.
  task automatic press(input logic ld, input logic st);
    Load_Btn  = ld;
    Start_Btn = st;
    repeat (10) tick();
    Load_Btn  = 1'b0;
    Start_Btn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    Reset = 1'b0; Load_Btn = 1'b0; Start_Btn = 1'b0; Stop = 6'd0; Count = 6'd0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    check("rst_target", Target, 0);
    check("rst_count_en", Count_En, 0);
    check("rst_clr", Counter_Clr, 0);
    check("rst_done", Done, 0);
    check("rst_load_err", Load_Err, 0);

    // Glitch shorter than the debounce window
    Load_Btn = 1'b1;
    repeat (3) tick();
    Load_Btn = 1'b0;
    repeat (10) tick();
    check("glitch_no_clr", clr_cnt, 0);
    check("glitch_target", Target, 0);

    // Clean load with exact pulse timing
    Stop = 6'd25;
    Load_Btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) check("ld_clr_edge5", Counter_Clr, 0);
      if (i == 6) check("ld_clr_edge6", Counter_Clr, 1);
      if (i == 7) check("ld_clr_edge7", Counter_Clr, 0);
    end
    Load_Btn = 1'b0;
    repeat (10) tick();
    check("ld25_target", Target, 25);
    check("ld25_clr_count", clr_cnt, 1);
    check("ld25_count_en", Count_En, 0);

    // Out-of-range then maximum legal target
    Stop = 6'd60;
    press(1'b1, 1'b0);
    check("ld60_err", Load_Err, 1);
    check("ld60_target", Target, 25);
    check("ld60_no_clr", clr_cnt, 1);
    Stop = 6'd59;
    press(1'b1, 1'b0);
    check("ld59_err", Load_Err, 0);
    check("ld59_target", Target, 59);

    // Run to target 5
    Stop = 6'd5;
    press(1'b1, 1'b0);
    check("ld5_target", Target, 5);
    press(1'b0, 1'b1);
    check("run5_count_en", Count_En, 1);
    for (int c = 1; c <= 4; c++) begin
      Count = 6'(c);
      tick();
      check("run5_still_en", Count_En, 1);
    end
    Count = 6'd5;
    check("run5_pre_edge_en", Count_En, 1);
    tick();
    check("run5_done_en", Count_En, 0);
    check("run5_done", Done, 1);
    press(1'b0, 1'b1);
    check("done_start_done", Done, 1);
    check("done_start_en", Count_En, 0);

    // Pause / resume, load ignored while running
    Stop = 6'd30;
    press(1'b1, 1'b0);
    Count = 6'd0;
    check("ld30_done_clr", Done, 0);
    press(1'b0, 1'b1);
    check("run30_en", Count_En, 1);
    press(1'b0, 1'b1);
    check("pause_en", Count_En, 0);
    check("pause_target", Target, 30);
    press(1'b0, 1'b1);
    check("resume_en", Count_En, 1);
    clr_base = clr_cnt;
    Stop = 6'd10;
    press(1'b1, 1'b0);
    check("run_ld_target", Target, 30);
    check("run_ld_no_clr", clr_cnt, clr_base);
    check("run_ld_en", Count_En, 1);

    // Reset mid-RUNNING with Target=20 and Load_Err set
    press(1'b0, 1'b1);
    Stop = 6'd20;
    press(1'b1, 1'b0);
    Stop = 6'd60;
    press(1'b1, 1'b0);
    check("pre_rst_err", Load_Err, 1);
    press(1'b0, 1'b1);
    check("pre_rst_target", Target, 20);
    check("pre_rst_en", Count_En, 1);
    Reset = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    check("mid_rst_target", Target, 0);
    check("mid_rst_en", Count_En, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_err", Load_Err, 0);
    tick();
    check("mid_rst_idle_en", Count_En, 0);

    // Coincident Load and Start in ARMED
    Stop = 6'd3;
    press(1'b1, 1'b0);
    clr_base = clr_cnt;
    Stop = 6'd7;
    press(1'b1, 1'b1);
    check("both_target", Target, 7);
    check("both_clr", clr_cnt, clr_base + 1);
    check("both_en", Count_En, 0);

    // Target 0: DONE one cycle after entering RUNNING
    Stop = 6'd0;
    press(1'b1, 1'b0);
    check("ld0_target", Target, 0);
    Count = 6'd0;
    Start_Btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) begin
        check("t0_edge6_en", Count_En, 1);
        check("t0_edge6_done", Done, 0);
      end
      if (i == 7) begin
        check("t0_edge7_en", Count_En, 0);
        check("t0_edge7_done", Done, 1);
      end
    end
    Start_Btn = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
